// File: rtl/regbank_v5_pkg.sv
// regbank_v5_pkg: definitions shared by the regbank_v5 register file and its
// clear engine.
//   state_t  - clear-engine state encoding (IDLE=0, SWEEP=1)
//   depth_of - number of entries addressed by an index of the given width
package regbank_v5_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int unsigned DEF_AWIDTH = 5;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned DEF_DEPTH = depth_of(DEF_AWIDTH);

endpackage

// File: rtl/regbank_clr_fsm.sv
// regbank_clr_fsm: sequential clear engine for regbank_v5.
// It sweeps one array entry per cycle so the array needs no reset and can be
// mapped to RAM.
//   clk      - system clock
//   reset    - synchronous active-low reset; restarts the sweep from entry 0
//   clear    - soft-clear request; it is only honoured while idle
//   write    - write enable from the datapath, used to flag dropped writes
//   busy     - sweep in progress
//   wr_drop  - one-cycle pulse: a write was discarded because busy was 1
//   clr_we   - zero-write strobe to the array
//   clr_addr - entry being zeroed
module regbank_clr_fsm
  import regbank_v5_pkg::*;
#(
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              write,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr
);

  localparam int unsigned DEPTH = depth_of(AWIDTH);

  state_t            state, state_n;
  logic [AWIDTH-1:0] ptr, ptr_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= SWEEP;
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      wr_drop <= write & busy;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end
      end
      SWEEP: begin
        ptr_n = ptr + 1'b1;
        if (ptr == AWIDTH'(DEPTH - 1)) state_n = IDLE;
      end
      default: state_n = SWEEP;
    endcase
  end

  // busy is decoded from the state register, so it matches a registered flag
  // that is set on reset or clear and cleared on the last sweep edge.
  assign busy     = (state == SWEEP);
  assign clr_we   = busy & reset;
  assign clr_addr = ptr;

endmodule

// File: rtl/regbank_v5.sv
// regbank_v5: parametrised register file with 2 read ports and 1 write port.
// It supports an optional hardwired-zero entry 0, optional write-to-read
// bypass and a sequential clear engine.
//   clk, reset       - clock and synchronous active-low reset
//   sr1, sr2         - read indices
//   dr, wrData       - write index and data
//   write            - write enable
//   clear            - soft-clear request
//   rdData1, rdData2 - combinational read data (forced to 0 while busy)
//   busy             - clear sweep in progress
//   wr_drop          - pulse: a write was discarded during a sweep
module regbank_v5
  import regbank_v5_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AWIDTH   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] sr1,
  input  logic [AWIDTH-1:0] sr2,
  input  logic [AWIDTH-1:0] dr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              write,
  input  logic              clear,
  output logic [WIDTH-1:0]  rdData1,
  output logic [WIDTH-1:0]  rdData2,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = depth_of(AWIDTH);

  logic [WIDTH-1:0]  regfile [DEPTH];
  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;
  logic              user_we;

  regbank_clr_fsm #(.AWIDTH(AWIDTH)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .write    (write),
    .busy     (busy),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign user_we = write & ~busy & reset & ~((ZERO_REG != 0) && (dr == '0));

  // Single write port: the sweep and user writes are mutually exclusive
  // (user writes require busy=0), so the array stays RAM-mappable.
  always_ff @(posedge clk) begin
    if (clr_we)       regfile[clr_addr] <= '0;
    else if (user_we) regfile[dr]       <= wrData;
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AWIDTH-1:0] sr);
    if (busy)                                     return '0;
    else if ((ZERO_REG != 0) && (sr == '0))       return '0;
    else if ((BYPASS != 0) && write && (dr == sr)) return wrData;
    else                                          return regfile[sr];
  endfunction

  always_comb begin
    rdData1 = read_port(sr1);
    rdData2 = read_port(sr2);
  end

endmodule
